// File: rtl/holy_axil_ram.sv
// ---------------------------------------------------------------------------
// holy_axil_ram
//
// Word-addressed 32-bit RAM behind an AXI-Lite responder. Only one write is
// in flight at a time. The read path runs independently of the write path.
//
// Handshake rule for every channel (AW, W, B, AR, R): a transfer occurs on a
// rising clk edge at which both valid and ready are high. A sender holds
// valid and its payload stable until that edge. All readies and all response
// outputs come straight from flops.
//
// Parameters
//   BASE_ADDR : byte base address of the RAM window (4-byte aligned)
//   DEPTH     : number of 32-bit words (power of two, >= 2)
//
// Ports
//   clk                      : sole clock, rising edge
//   rst_n                    : synchronous active-low reset
//   s_axi_lite_aw*           : write address channel (awaddr, awvalid, awready)
//   s_axi_lite_w*            : write data channel (wdata, wstrb, wvalid, wready)
//   s_axi_lite_b*            : write response channel (bresp, bvalid, bready)
//   s_axi_lite_ar*           : read address channel (araddr, arvalid, arready)
//   s_axi_lite_r*            : read data channel (rdata, rresp, rvalid, rready)
//
// Addresses outside [BASE_ADDR, BASE_ADDR + 4*DEPTH) answer SLVERR. An
// out-of-range write leaves memory untouched. An out-of-range read returns 0.
// Memory contents are not reset.
// ---------------------------------------------------------------------------
module holy_axil_ram #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic [31:0] s_axi_lite_awaddr,
  input  logic        s_axi_lite_awvalid,
  output logic        s_axi_lite_awready,

  input  logic [31:0] s_axi_lite_wdata,
  input  logic [3:0]  s_axi_lite_wstrb,
  input  logic        s_axi_lite_wvalid,
  output logic        s_axi_lite_wready,

  output logic [1:0]  s_axi_lite_bresp,
  output logic        s_axi_lite_bvalid,
  input  logic        s_axi_lite_bready,

  input  logic [31:0] s_axi_lite_araddr,
  input  logic        s_axi_lite_arvalid,
  output logic        s_axi_lite_arready,

  output logic [31:0] s_axi_lite_rdata,
  output logic [1:0]  s_axi_lite_rresp,
  output logic        s_axi_lite_rvalid,
  input  logic        s_axi_lite_rready
);

  localparam int         IDX_W       = $clog2(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // The subtraction is done in 33 bits. An address below BASE_ADDR therefore
  // wraps to a value with bit 32 set, and it fails the single upper-bound
  // compare. This avoids a separate lower-bound compare, which would be a
  // constant-true test when BASE_ADDR is 0.
  function automatic logic addr_ok(input logic [31:0] a);
    return ({1'b0, a} - {1'b0, BASE_ADDR}) < 33'(4 * DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  logic [31:0] mem [DEPTH];

  // Write-path state: AW and W are captured independently.
  logic             aw_held;
  logic             w_held;
  logic [IDX_W-1:0] aw_idx;
  logic             aw_ok;
  logic [31:0]      w_data;
  logic [3:0]       w_strb;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic commit;
  logic aw_held_n;
  logic w_held_n;
  logic bvalid_n;
  logic rvalid_n;

  always_comb begin
    aw_hs     = s_axi_lite_awvalid && s_axi_lite_awready;
    w_hs      = s_axi_lite_wvalid  && s_axi_lite_wready;
    ar_hs     = s_axi_lite_arvalid && s_axi_lite_arready;
    // A commit happens once both halves of the write are held and no
    // response is pending. The readies are gated by the held flags, so a
    // new handshake can never coincide with a commit.
    commit    = aw_held && w_held && !s_axi_lite_bvalid;

    aw_held_n = aw_held;
    w_held_n  = w_held;
    if (commit) begin
      aw_held_n = 1'b0;
      w_held_n  = 1'b0;
    end else begin
      if (aw_hs) aw_held_n = 1'b1;
      if (w_hs)  w_held_n  = 1'b1;
    end

    bvalid_n = commit || (s_axi_lite_bvalid && !s_axi_lite_bready);
    rvalid_n = ar_hs  || (s_axi_lite_rvalid && !s_axi_lite_rready);
  end

  // Write channel control and response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_held            <= 1'b0;
      w_held             <= 1'b0;
      aw_idx             <= '0;
      aw_ok              <= 1'b0;
      w_data             <= '0;
      w_strb             <= '0;
      s_axi_lite_awready <= 1'b0;
      s_axi_lite_wready  <= 1'b0;
      s_axi_lite_bvalid  <= 1'b0;
      s_axi_lite_bresp   <= RESP_OKAY;
    end else begin
      aw_held            <= aw_held_n;
      w_held             <= w_held_n;
      // Readies are computed from next-state values. They drop on the edge
      // that captures a channel, and they reassert on the edge that retires
      // the B response.
      s_axi_lite_awready <= !aw_held_n && !bvalid_n;
      s_axi_lite_wready  <= !w_held_n  && !bvalid_n;
      s_axi_lite_bvalid  <= bvalid_n;
      if (aw_hs) begin
        aw_idx <= addr_idx(s_axi_lite_awaddr);
        aw_ok  <= addr_ok(s_axi_lite_awaddr);
      end
      if (w_hs) begin
        w_data <= s_axi_lite_wdata;
        w_strb <= s_axi_lite_wstrb;
      end
      if (commit) begin
        s_axi_lite_bresp <= aw_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Byte-lane writes. A commit is dropped if reset is asserted on that
  // edge. Words already written are kept across reset.
  always_ff @(posedge clk) begin
    if (rst_n && commit && aw_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (w_strb[i]) mem[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  // Read channel. The read samples mem with nonblocking semantics. A read
  // that lands on the same edge as a commit to the same word therefore
  // returns the old contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_axi_lite_arready <= 1'b0;
      s_axi_lite_rvalid  <= 1'b0;
      s_axi_lite_rresp   <= RESP_OKAY;
      s_axi_lite_rdata   <= '0;
    end else begin
      s_axi_lite_arready <= !rvalid_n;
      s_axi_lite_rvalid  <= rvalid_n;
      if (ar_hs) begin
        if (addr_ok(s_axi_lite_araddr)) begin
          s_axi_lite_rdata <= mem[addr_idx(s_axi_lite_araddr)];
          s_axi_lite_rresp <= RESP_OKAY;
        end else begin
          s_axi_lite_rdata <= '0;
          s_axi_lite_rresp <= RESP_SLVERR;
        end
      end
    end
  end

endmodule

// File: tb/tb_holy_axil_ram.sv
// ---------------------------------------------------------------------------
// tb_holy_axil_ram
//
// Bench for holy_axil_ram. Driver tasks issue AXI-Lite transactions. Each
// task pushes the expected response into a queue, computed from a word-level
// reference memory. A free-running monitor pops and compares on every B and R
// handshake, and it also checks response latency. Directed scenarios cover
// reset, ordering, out-of-range access, back-pressure, mid-transaction reset
// and the same-cycle commit/read case. They are followed by randomized
// traffic.
// ---------------------------------------------------------------------------
module tb_holy_axil_ram;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  holy_axil_ram #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .s_axi_lite_awaddr  (awaddr),
    .s_axi_lite_awvalid (awvalid),
    .s_axi_lite_awready (awready),
    .s_axi_lite_wdata   (wdata),
    .s_axi_lite_wstrb   (wstrb),
    .s_axi_lite_wvalid  (wvalid),
    .s_axi_lite_wready  (wready),
    .s_axi_lite_bresp   (bresp),
    .s_axi_lite_bvalid  (bvalid),
    .s_axi_lite_bready  (bready),
    .s_axi_lite_araddr  (araddr),
    .s_axi_lite_arvalid (arvalid),
    .s_axi_lite_arready (arready),
    .s_axi_lite_rdata   (rdata),
    .s_axi_lite_rresp   (rresp),
    .s_axi_lite_rvalid  (rvalid),
    .s_axi_lite_rready  (rready)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [1:0]  b_exp_q[$];
  logic [33:0] r_exp_q[$];     // {rresp, rdata}
  logic [31:0] ref_mem [int];  // keyed by word number
  int          aw_hs_cyc = 0;
  int          w_hs_cyc  = 0;
  int          ar_hs_cyc = 0;
  bit          rand_ready = 1'b0;
  bit          stall = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit ref_in_range(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic int ref_word(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (!ref_in_range(a)) return 32'h0;
    return ref_mem[ref_word(a)];
  endfunction

  function automatic logic [1:0] ref_resp(input logic [31:0] a);
    return ref_in_range(a) ? 2'b00 : 2'b10;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (ref_in_range(a)) begin
      w = ref_mem.exists(ref_word(a)) ? ref_mem[ref_word(a)] : 32'hx;
      for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
      ref_mem[ref_word(a)] = w;
    end
  endtask

  // ---------------- ready generator (sole driver of bready/rready) -------
  initial begin
    bready = 1'b1;
    rready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall) begin
        bready = 1'b0;
        rready = 1'b0;
      end else if (rand_ready) begin
        bready = ($urandom_range(0, 3) != 0);
        rready = ($urandom_range(0, 3) != 0);
      end else begin
        bready = 1'b1;
        rready = 1'b1;
      end
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send_aw(input logic [31:0] a, input int dly);
    bit hs = 1'b0;
    int n = 0;
    repeat (dly) begin @(posedge clk); #1; end
    awaddr  = a;
    awvalid = 1'b1;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = awready;
      @(posedge clk);
      #1;
      n++;
    end
    awvalid = 1'b0;
    awaddr  = $urandom();
    if (hs) aw_hs_cyc = cyc;
    chk("aw_handshake", 64'(hs), 64'd1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    bit hs = 1'b0;
    int n = 0;
    repeat (dly) begin @(posedge clk); #1; end
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = wready;
      @(posedge clk);
      #1;
      n++;
    end
    wvalid = 1'b0;
    wdata  = $urandom();
    wstrb  = 4'($urandom());
    if (hs) w_hs_cyc = cyc;
    chk("w_handshake", 64'(hs), 64'd1);
  endtask

  task automatic send_ar(input logic [31:0] a, input int dly);
    bit hs = 1'b0;
    int n = 0;
    repeat (dly) begin @(posedge clk); #1; end
    araddr  = a;
    arvalid = 1'b1;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = arready;
      @(posedge clk);
      #1;
      n++;
    end
    arvalid = 1'b0;
    araddr  = $urandom();
    if (hs) ar_hs_cyc = cyc;
    chk("ar_handshake", 64'(hs), 64'd1);
  endtask

  task automatic wait_b();
    int n = 0;
    while (b_exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("b_response_timeout", 64'(b_exp_q.size()), 64'd0);
    b_exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_r();
    int n = 0;
    while (r_exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("r_response_timeout", 64'(r_exp_q.size()), 64'd0);
    r_exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly);
    b_exp_q.push_back(ref_resp(a));
    ref_write(a, d, s);
    fork
      send_aw(a, aw_dly);
      send_w(d, s, w_dly);
    join
    wait_b();
  endtask

  task automatic do_read(input logic [31:0] a, input int dly);
    r_exp_q.push_back({ref_resp(a), ref_read(a)});
    send_ar(a, dly);
    wait_r();
  endtask

  function automatic logic [31:0] rand_in_addr();
    return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] rand_out_addr();
    case ($urandom_range(0, 4))
      0:       return BASE - 32'd4;
      1:       return BASE - 32'd1;
      2:       return BASE + 32'(4 * DEPTH);
      3:       return 32'hFFFF_FFFC;
      default: return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 4096));
    endcase
  endfunction

  // Runs during the back-pressure scenario. It checks that stalled responses
  // and their payloads hold steady while every ready stays low.
  task automatic stall_checker();
    int n = 0;
    logic [1:0]  bq;
    logic [1:0]  rq;
    logic [31:0] rd;
    while (!(bvalid && rvalid) && n < 20) begin @(negedge clk); n++; end
    chk("stall_valids_up", 64'(bvalid && rvalid), 64'd1);
    bq = bresp;
    rq = rresp;
    rd = rdata;
    repeat (10) begin
      @(negedge clk);
      chk("stall_bvalid", 64'(bvalid), 64'd1);
      chk("stall_rvalid", 64'(rvalid), 64'd1);
      chk("stall_bresp", 64'(bresp), 64'(bq));
      chk("stall_rresp", 64'(rresp), 64'(rq));
      chk("stall_rdata", 64'(rdata), 64'(rd));
      chk("stall_readies", 64'({awready, wready, arready}), 64'd0);
    end
    @(posedge clk);
    #1;
    stall = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    bit          pb;
    bit          pr;
    logic [1:0]  eb;
    logic [33:0] er;
    pb = 1'b0;
    pr = 1'b0;
    forever begin
      @(negedge clk);
      if (bvalid && !pb)
        chk("b_latency", 64'(cyc - ((aw_hs_cyc > w_hs_cyc) ? aw_hs_cyc : w_hs_cyc)), 64'd1);
      if (bvalid && bready) begin
        if (b_exp_q.size() == 0) chk("b_unexpected", 64'(bvalid), 64'd0);
        else begin
          eb = b_exp_q.pop_front();
          chk("bresp", 64'(bresp), 64'(eb));
        end
      end
      pb = bvalid;
      if (rvalid && !pr) chk("r_latency", 64'(cyc - ar_hs_cyc), 64'd0);
      if (rvalid && rready) begin
        if (r_exp_q.size() == 0) chk("r_unexpected", 64'(rvalid), 64'd0);
        else begin
          er = r_exp_q.pop_front();
          chk("rresp", 64'(rresp), 64'(er[33:32]));
          chk("rdata", 64'(rdata), 64'(er[31:0]));
        end
      end
      pr = rvalid;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] a2;
    int          wi;
    int          ri;
    int          op;

    rst_n   = 1'b0;
    awaddr  = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wvalid  = 1'b0;
    araddr  = '0;
    arvalid = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_readies", 64'({awready, wready, arready}), 64'd0);
    chk("reset_valids", 64'({bvalid, rvalid}), 64'd0);
    chk("reset_resps", 64'({bresp, rresp}), 64'd0);
    chk("reset_rdata", 64'(rdata), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_reset_readies", 64'({awready, wready, arready}), 64'b111);
    @(posedge clk);
    #1;

    // Fill every word so reads have known contents.
    rand_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      do_write(BASE + 32'(4 * i), $urandom(), 4'hF, $urandom_range(0, 2), $urandom_range(0, 2));
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // AW and W together, then read back.
    do_write(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    do_read(BASE + 32'h10, 0);

    // W arrives three cycles before AW. Partial strobes merge into the old word.
    do_write(BASE + 32'd36, 32'hAAAAAAAA, 4'hF, 0, 0);
    b_exp_q.push_back(2'b00);
    ref_write(BASE + 32'd36, 32'h11223344, 4'b0101);
    fork
      send_w(32'h11223344, 4'b0101, 0);
      send_aw(BASE + 32'd36, 3);
      begin
        repeat (2) begin
          @(negedge clk);
          chk("awready_while_w_only", 64'(awready), 64'd1);
        end
      end
    join
    wait_b();
    do_read(BASE + 32'd36, 0);
    do_write(BASE + 32'd40, $urandom(), 4'b0000, 0, 0);
    do_read(BASE + 32'd40, 0);

    // Out-of-range write and read, then confirm no word changed.
    do_write(BASE + 32'(4 * DEPTH), $urandom(), 4'hF, 0, 0);
    do_write(32'hFFFF_FFFC, $urandom(), 4'hF, 1, 0);
    do_read(BASE - 32'd4, 0);
    for (int i = 0; i < DEPTH; i++) do_read(BASE + 32'(4 * i), 0);

    // Back-pressure on both response channels for 10 cycles.
    stall = 1'b1;
    @(posedge clk);
    #1;
    fork
      do_write(BASE + 32'd12, $urandom(), 4'hF, 0, 0);
      do_read(BASE + 32'd28, 0);
      stall_checker();
    join

    // Reset pulse after an AW handshake but before W.
    send_aw(BASE + 32'd8, 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_readies", 64'({awready, wready, arready}), 64'd0);
    chk("midreset_valids", 64'({bvalid, rvalid}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("after_midreset_readies", 64'({awready, wready, arready}), 64'b111);
    @(posedge clk);
    #1;
    do_read(BASE + 32'd8, 0);
    do_write(BASE + 32'd8, $urandom(), 4'hF, 1, 0);
    do_read(BASE + 32'd8, 0);

    // Commit to word 5 on the same edge as an AR to word 5.
    do_write(BASE + 32'd20, 32'h0, 4'hF, 0, 0);
    r_exp_q.push_back({2'b00, ref_read(BASE + 32'd20)});
    b_exp_q.push_back(2'b00);
    ref_write(BASE + 32'd20, 32'h5, 4'hF);
    fork
      send_aw(BASE + 32'd20, 0);
      send_w(32'h5, 4'hF, 0);
      send_ar(BASE + 32'd20, 1);
    join
    chk("ar_on_commit_edge", 64'(ar_hs_cyc),
        64'(((aw_hs_cyc > w_hs_cyc) ? aw_hs_cyc : w_hs_cyc) + 1));
    wait_b();
    wait_r();
    do_read(BASE + 32'd20, 0);

    // Randomized traffic with random response back-pressure.
    rand_ready = 1'b1;
    for (int k = 0; k < 80; k++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: do_write(rand_in_addr(), $urandom(), 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        1: do_read(rand_in_addr(), $urandom_range(0, 2));
        2: begin
          wi = $urandom_range(0, DEPTH - 1);
          ri = (wi + 1 + $urandom_range(0, DEPTH - 2)) % DEPTH;
          a  = BASE + 32'(4 * wi);
          a2 = BASE + 32'(4 * ri);
          fork
            do_write(a, $urandom(), 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2));
            do_read(a2, $urandom_range(0, 2));
          join
        end
        default: begin
          if ($urandom_range(0, 1) == 0)
            do_write(rand_out_addr(), $urandom(), 4'hF, 0, $urandom_range(0, 2));
          else
            do_read(rand_out_addr(), 0);
        end
      endcase
    end
    rand_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) do_read(BASE + 32'(4 * i), 0);

    repeat (5) @(posedge clk);
    chk("drain_b_queue", 64'(b_exp_q.size()), 64'd0);
    chk("drain_r_queue", 64'(r_exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/holy_axil_ram.md
HOLY_AXIL_RAM -- requirements
Module: holy_axil_ram

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte base address of the RAM window (4-byte aligned).
REQ-002 SHALL have parameter DEPTH, default 1024, number of 32-bit words (power of two, >= 2).
REQ-003 SHALL have ports: clk, input, 1, sole clock; all logic rising-edge.
REQ-004 SHALL have ports: rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have ports: s_axi_lite_awaddr in 32 and s_axi_lite_awvalid in 1, which carry the write address and its valid; s_axi_lite_awready out 1 is the write-address ready.
REQ-006 SHALL have ports: s_axi_lite_wdata in 32, s_axi_lite_wstrb in 4 and s_axi_lite_wvalid in 1, which carry the write data, byte strobes and valid; s_axi_lite_wready out 1 is the write-data ready.
REQ-007 SHALL have ports: s_axi_lite_bresp out 2 and s_axi_lite_bvalid out 1, which carry the write response and its valid; s_axi_lite_bready in 1 is the response ready.
REQ-008 SHALL have ports: s_axi_lite_araddr in 32 and s_axi_lite_arvalid in 1, which carry the read address and its valid; s_axi_lite_arready out 1 is the read-address ready.
REQ-009 SHALL have ports: s_axi_lite_rdata out 32, s_axi_lite_rresp out 2 and s_axi_lite_rvalid out 1, which carry the read data, response and valid; s_axi_lite_rready in 1 is the read-data ready.

Function
REQ-010 SHALL be an AXI-Lite responder; a channel handshake occurs on a cycle where valid and ready are both high at the clk edge.
REQ-011 SHALL decode addresses as follows: offset = addr - BASE_ADDR, word index = offset[log2(DEPTH)+1:2], addr[1:0] ignored; addr is in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH (32-bit unsigned compare, no wrap).
REQ-012 SHALL, on the write path, latch AW and W independently (AW_HELD, W_HELD flags) in any order, including the same cycle.
REQ-013 SHALL hold awready = !AW_HELD && !bvalid and wready = !W_HELD && !bvalid, registered, so at most one write is outstanding.
REQ-014 SHALL, in the first cycle where both are held and bvalid=0, commit the write: for each i with wstrb[i]=1, mem[idx] byte i = wdata[8i+7:8i]; then clear both flags and set bvalid=1 on the next cycle.
REQ-015 SHALL, for an out-of-range write, modify no memory and return bresp=2'b10 (SLVERR); in-range writes return 2'b00 (OKAY); wstrb=4'b0000 is OKAY with no change.
REQ-016 SHALL hold bvalid and bresp stable until the bready handshake; bvalid deasserts the cycle after; awready/wready may reassert that same following cycle.
REQ-017 SHALL have a minimum write latency of 1 cycle, measured from the cycle after the last of the AW/W handshakes to bvalid=1.
REQ-018 SHALL, on the read path, hold arready = !rvalid, registered; on the AR handshake, rdata = mem[idx], rresp and rvalid=1 are registered on the following edge (1-cycle latency).
REQ-019 SHALL, for an out-of-range read, return rdata=32'h0 and rresp=2'b10; in-range reads return 2'b00.
REQ-020 SHALL hold rdata/rresp/rvalid stable until the rready handshake; rvalid clears the cycle after, and arready reasserts with it; back-to-back reads therefore sustain one read per 2 cycles.
REQ-021 SHALL, when a write commit and an AR handshake address the same word in the same cycle, return the pre-write (old) data on the read.
REQ-022 SHALL operate the read and write paths fully independently; simultaneous activity on both SHALL NOT stall either.
REQ-023 SHALL treat any change of awaddr/wdata/araddr while valid is low, or after handshake, as having no effect.

Reset
REQ-024 SHALL, while rst_n=0 at a clk edge, force awready=0, wready=0, arready=0, bvalid=0, rvalid=0, bresp=2'b00, rresp=2'b00, rdata=32'h0, and clear AW_HELD/W_HELD.
REQ-025 SHALL assert awready=1, wready=1 and arready=1 on the first edge with rst_n=1.
REQ-026 SHALL, on reset mid-transaction, discard latched AW/W and pending B/R responses; a write already committed SHALL remain in memory.
REQ-027 SHALL NOT reset memory contents.

Verification
REQ-028 SHALL be verified by: AW=BASE+0x10 and W=32'hDEADBEEF/wstrb=4'hF in the same cycle, then AR at the same address -> bresp=00 one cycle after the commit, then rdata=32'hDEADBEEF, rresp=00, one cycle after the AR handshake.
REQ-029 SHALL be verified by: W (32'h11223344, wstrb=4'b0101) sent 3 cycles before AW at a word holding 32'hAAAAAAAA -> awready=1 on W arrival, and a subsequent read returns 32'hAA22AA44.
REQ-030 SHALL be verified by: a write to BASE+4*DEPTH and a read at BASE-4 -> bresp=2'b10, rresp=2'b10, rdata=0, and no memory word changed.
REQ-031 SHALL be verified by: bready and rready held low for 10 cycles -> bvalid/rvalid and their data stay constant, and awready=wready=arready=0 throughout.
REQ-032 SHALL be verified by: rst_n pulsed low for 1 cycle after an AW handshake but before W -> all valids 0 and readies 0 during reset, readies 1 after; a new full write completes normally.
REQ-033 SHALL be verified by: a commit to word 5 (old 32'h0, new 32'h5) in the same cycle as an AR to word 5 -> rdata=32'h0, and the next read returns 32'h5.
